arr_drv: RTL

//  Stimulus transmitter for the arr pair checker: drives sig0/sig1 LENGTH-bit vector pairs from a 32-bit LFSR.

---
 rtl/arr_pkg.sv | 14 +
 rtl/arr_drv_if.sv | 30 +++
 rtl/arr_drv_lfsr.sv | 27 ++
 rtl/arr_drv.sv | 131 +++++++++++++
 4 files changed

// File: rtl/arr_pkg.sv
// Shared types, LFSR constants and the LFSR step function for the arr pair-checker stimulus driver.
package arr_pkg;

    typedef enum logic [1:0] {ARR_IDLE, ARR_RUN, ARR_DONE} arr_state_t;

    localparam int ARR_LFSR_W = 32;
    localparam logic [ARR_LFSR_W-1:0] ARR_LFSR_POLY_C = 32'h80200003;

    // Galois form, right shift: the feedback poly is applied when the bit shifted out is 1.
    function automatic logic [ARR_LFSR_W-1:0] arr_lfsr_next(input logic [ARR_LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? ARR_LFSR_POLY_C : {ARR_LFSR_W{1'b0}});
    endfunction

endpackage

// File: rtl/arr_drv_if.sv
// Control and vector-pair bus of arr_drv; slave is the driver, master is whoever starts runs.
interface arr_drv_if
    import arr_pkg::*;
#(
    parameter int LENGTH    = 1,
    parameter int MAX_VEC_W = 16
);
    logic                 arr_drv_start_ip;
    logic [MAX_VEC_W-1:0] arr_drv_count_ip;
    logic [MAX_VEC_W-1:0] arr_drv_inject_ip;
    logic [LENGTH-1:0]    arr_drv_sig0_op;
    logic [LENGTH-1:0]    arr_drv_sig1_op;
    logic                 arr_drv_valid_op;
    logic                 arr_drv_busy_op;
    logic                 arr_drv_done_op;
    logic [MAX_VEC_W-1:0] arr_drv_sent_op;

    modport master (
        output arr_drv_start_ip, arr_drv_count_ip, arr_drv_inject_ip,
        input  arr_drv_sig0_op, arr_drv_sig1_op, arr_drv_valid_op,
        input  arr_drv_busy_op, arr_drv_done_op, arr_drv_sent_op
    );

    modport slave (
        input  arr_drv_start_ip, arr_drv_count_ip, arr_drv_inject_ip,
        output arr_drv_sig0_op, arr_drv_sig1_op, arr_drv_valid_op,
        output arr_drv_busy_op, arr_drv_done_op, arr_drv_sent_op
    );

endinterface

// File: rtl/arr_drv_lfsr.sv
// 32-bit Galois LFSR holding register: loads the seed on reset, steps when adv is high.
module arr_drv_lfsr
    import arr_pkg::*;
#(
    parameter logic [ARR_LFSR_W-1:0] SEED = 32'h1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  adv,
    output logic [ARR_LFSR_W-1:0] lfsr_state
);
    // An all-zero state would lock up the LFSR, so a zero seed becomes 1.
    localparam logic [ARR_LFSR_W-1:0] SEED_C = (SEED == '0) ? 32'h1 : SEED;

    logic [ARR_LFSR_W-1:0] state_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= SEED_C;
        end else if (adv) begin
            state_reg <= arr_lfsr_next(state_reg);
        end
    end

    assign lfsr_state = state_reg;

endmodule

// File: rtl/arr_drv.sv
// Stimulus driver for the arr pair checker: streams LFSR vector pairs, optionally corrupting one.
// Define ARR_DRV_TRACE_EN to log every valid vector and the end of each run.
module arr_drv
    import arr_pkg::*;
#(
    parameter int                    LENGTH    = 1,
    parameter logic [ARR_LFSR_W-1:0] SEED      = 32'h1,
    parameter int                    MAX_VEC_W = 16
) (
    input logic      arr_drv_clk_ip,
    input logic      arr_drv_rst_ip,
    arr_drv_if.slave bus
);
    arr_state_t           state_reg, state_next;
    logic [LENGTH-1:0]    sig0_reg, sig0_next;
    logic [LENGTH-1:0]    sig1_reg, sig1_next;
    logic [MAX_VEC_W-1:0] count_reg, count_next;
    logic [MAX_VEC_W-1:0] inject_reg, inject_next;
    logic [MAX_VEC_W-1:0] sent_reg, sent_next;

    logic                  lfsr_adv;
    logic [ARR_LFSR_W-1:0] lfsr_state;
    logic [ARR_LFSR_W-1:0] lfsr_next;
    logic [LENGTH-1:0]     vec;
    logic [LENGTH-1:0]     lsb_mask;
    logic                  lfsr_unused;

    arr_drv_lfsr #(.SEED(SEED)) u_lfsr (
        .clk        (arr_drv_clk_ip),
        .srst       (arr_drv_rst_ip),
        .adv        (lfsr_adv),
        .lfsr_state (lfsr_state)
    );

    assign lfsr_next = arr_lfsr_next(lfsr_state);
    // Narrow builds leave upper LFSR bits unconnected; this folds them into a sink.
    assign lfsr_unused = ^lfsr_next;
    assign lsb_mask    = LENGTH'(1);

    // The vector is the LFSR state replicated out to LENGTH bits.
    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_vec
        assign vec[gi] = lfsr_next[gi % ARR_LFSR_W];
    end

    always_ff @(posedge arr_drv_clk_ip) begin
        if (arr_drv_rst_ip) begin
            state_reg  <= ARR_IDLE;
            sig0_reg   <= '0;
            sig1_reg   <= '0;
            count_reg  <= '0;
            inject_reg <= '0;
            sent_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            sig0_reg   <= sig0_next;
            sig1_reg   <= sig1_next;
            count_reg  <= count_next;
            inject_reg <= inject_next;
            sent_reg   <= sent_next;
        end
    end

    // RUN means "a vector is on the outputs this cycle": entering RUN already emits vector 1.
    always_comb begin
        state_next  = state_reg;
        sig0_next   = sig0_reg;
        sig1_next   = sig0_reg;
        count_next  = count_reg;
        inject_next = inject_reg;
        sent_next   = sent_reg;
        lfsr_adv    = 1'b0;
        unique case (state_reg)
            ARR_IDLE: begin
                if (bus.arr_drv_start_ip) begin
                    count_next  = bus.arr_drv_count_ip;
                    inject_next = bus.arr_drv_inject_ip;
                    if (bus.arr_drv_count_ip != '0) begin
                        state_next = ARR_RUN;
                        sent_next  = MAX_VEC_W'(1);
                        lfsr_adv   = 1'b1;
                        sig0_next  = vec;
                        sig1_next  = (bus.arr_drv_inject_ip == MAX_VEC_W'(1)) ? (vec ^ lsb_mask) : vec;
                    end else begin
                        state_next = ARR_DONE;
                        sent_next  = '0;
                    end
                end
            end
            ARR_RUN: begin
                if (sent_reg == count_reg) begin
                    state_next = ARR_DONE;
                end else begin
                    sent_next = sent_reg + MAX_VEC_W'(1);
                    lfsr_adv  = 1'b1;
                    sig0_next = vec;
                    sig1_next = (sent_next == inject_reg) ? (vec ^ lsb_mask) : vec;
                end
            end
            ARR_DONE: begin
                state_next = ARR_IDLE;
            end
            default: begin
                state_next = ARR_IDLE;
            end
        endcase
    end

    assign bus.arr_drv_sig0_op  = sig0_reg;
    assign bus.arr_drv_sig1_op  = sig1_reg;
    assign bus.arr_drv_valid_op = (state_reg == ARR_RUN);
    assign bus.arr_drv_busy_op  = (state_reg == ARR_RUN);
    assign bus.arr_drv_done_op  = (state_reg == ARR_DONE);
    assign bus.arr_drv_sent_op  = sent_reg;

`ifdef ARR_DRV_TRACE_EN
`ifndef EXM_INFORMATION
`define EXM_INFORMATION(msg) $display("%s", msg)
`endif
    always_ff @(posedge arr_drv_clk_ip) begin
        if (!arr_drv_rst_ip) begin
            if (state_reg == ARR_RUN) begin
                `EXM_INFORMATION($sformatf("%m : vec %d %x %x", sent_reg, sig0_reg, sig1_reg));
            end
            if (state_reg == ARR_DONE) begin
                `EXM_INFORMATION($sformatf("%m : done %d vectors", sent_reg));
            end
        end
    end
`endif

endmodule
